// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA timing generator: per-axis timing
// fields, region codes, FSM states and the total/validity arithmetic.
package vga_pkg;

  localparam int VGA_CNT_WIDTH = 12;

  typedef struct packed {
    logic [VGA_CNT_WIDTH-1:0] active;
    logic [VGA_CNT_WIDTH-1:0] fp;
    logic [VGA_CNT_WIDTH-1:0] sync;
    logic [VGA_CNT_WIDTH-1:0] bp;
  } vga_axis_cfg_t;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} vga_region_e;

  typedef enum logic {ST_IDLE, ST_RUN} vga_state_e;

  // Two guard bits so four full-scale fields can never wrap.
  function automatic logic [VGA_CNT_WIDTH+1:0] axis_total(input vga_axis_cfg_t c);
    return {2'b00, c.active} + {2'b00, c.fp} + {2'b00, c.sync} + {2'b00, c.bp};
  endfunction

  // A line/frame may be at most 2^CNT_WIDTH long so total-1 fits the counter.
  function automatic logic axis_valid(input vga_axis_cfg_t c);
    logic [VGA_CNT_WIDTH+1:0] max_total;
    max_total = {2'b01, {VGA_CNT_WIDTH{1'b0}}};
    return (c.active != '0) && (c.sync != '0) && (axis_total(c) <= max_total);
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One timing axis: a wrapping position counter plus decode of which region
// (active / front porch / sync / back porch) the current position is in.
module vga_axis_counter
  import vga_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc_en,
  input  vga_axis_cfg_t            cfg,
  output logic [VGA_CNT_WIDTH-1:0] cnt,
  output logic                     wrap,
  output vga_region_e              region
);

  localparam int W = VGA_CNT_WIDTH;

  logic [W-1:0] cnt_q, cnt_d;
  logic [W+1:0] total, cnt_ext, fp_end, sync_end;

  always_comb begin
    total    = axis_total(cfg);
    cnt_ext  = {2'b00, cnt_q};
    fp_end   = {2'b00, cfg.active} + {2'b00, cfg.fp};
    sync_end = fp_end + {2'b00, cfg.sync};
    wrap     = inc_en && (cnt_ext == (total - 1'b1));

    if (cnt_ext < {2'b00, cfg.active}) region = ACTIVE;
    else if (cnt_ext < fp_end)         region = FP;
    else if (cnt_ext < sync_end)       region = SYNC;
    else                               region = BP;

    cnt_d = cnt_q;
    if (clr || wrap) cnt_d = '0;
    else if (inc_en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: shadows the AXI-written timing config at frame
// boundaries and produces registered sync, data-enable and pixel coordinates.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CNT_WIDTH         = VGA_CNT_WIDTH,
  parameter logic DEFAULT_HSYNC_POL = 1'b0
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 cfg_enable,
  input  logic                 cfg_hsync_pol,
  input  logic                 cfg_vsync_pol,
  input  logic [CNT_WIDTH-1:0] cfg_h_active,
  input  logic [CNT_WIDTH-1:0] cfg_h_fp,
  input  logic [CNT_WIDTH-1:0] cfg_h_sync,
  input  logic [CNT_WIDTH-1:0] cfg_h_bp,
  input  logic [CNT_WIDTH-1:0] cfg_v_active,
  input  logic [CNT_WIDTH-1:0] cfg_v_fp,
  input  logic [CNT_WIDTH-1:0] cfg_v_sync,
  input  logic [CNT_WIDTH-1:0] cfg_v_bp,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [CNT_WIDTH-1:0] pix_x,
  output logic [CNT_WIDTH-1:0] pix_y,
  output logic                 frame_start,
  output logic                 running,
  output logic                 cfg_error
);

  vga_state_e           state_q, state_d;
  vga_axis_cfg_t        h_cfg_q, h_cfg_d, v_cfg_q, v_cfg_d, h_cfg_in, v_cfg_in;
  logic                 hpol_q, hpol_d, vpol_q, vpol_d;
  logic                 cfg_error_q, cfg_error_d;
  logic                 hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic                 frame_start_q, frame_start_d;
  logic [CNT_WIDTH-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [CNT_WIDTH-1:0] h_cnt, v_cnt;
  logic                 run, h_wrap, v_wrap, cfg_valid, latch;
  vga_region_e          h_region, v_region;

  assign h_cfg_in  = '{active: cfg_h_active, fp: cfg_h_fp, sync: cfg_h_sync, bp: cfg_h_bp};
  assign v_cfg_in  = '{active: cfg_v_active, fp: cfg_v_fp, sync: cfg_v_sync, bp: cfg_v_bp};
  assign cfg_valid = axis_valid(h_cfg_in) && axis_valid(v_cfg_in);
  assign run       = (state_q == ST_RUN);

  vga_axis_counter u_h_axis (
    .clk(ACLK), .rst(ARESET), .clr(!run), .inc_en(run),
    .cfg(h_cfg_q), .cnt(h_cnt), .wrap(h_wrap), .region(h_region)
  );

  // v_wrap already implies h_wrap, so it marks the last cycle of a frame.
  vga_axis_counter u_v_axis (
    .clk(ACLK), .rst(ARESET), .clr(!run), .inc_en(h_wrap),
    .cfg(v_cfg_q), .cnt(v_cnt), .wrap(v_wrap), .region(v_region)
  );

  always_comb begin
    state_d     = state_q;
    h_cfg_d     = h_cfg_q;
    v_cfg_d     = v_cfg_q;
    hpol_d      = hpol_q;
    vpol_d      = vpol_q;
    cfg_error_d = cfg_error_q;
    latch       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          if (cfg_valid) begin
            latch   = 1'b1;
            state_d = ST_RUN;
          end else begin
            cfg_error_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (v_wrap) begin
          if (!cfg_enable)    state_d     = ST_IDLE;
          else if (cfg_valid) latch       = 1'b1;
          else                cfg_error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (latch) begin
      h_cfg_d     = h_cfg_in;
      v_cfg_d     = v_cfg_in;
      hpol_d      = cfg_hsync_pol;
      vpol_d      = cfg_vsync_pol;
      cfg_error_d = 1'b0;
    end

    // Outputs describe the counter position of this cycle, one cycle late.
    hsync_d       = ~hpol_q;
    vsync_d       = ~vpol_q;
    de_d          = 1'b0;
    pix_x_d       = '0;
    pix_y_d       = '0;
    frame_start_d = 1'b0;
    if (run) begin
      hsync_d       = (h_region == SYNC) ? hpol_q : ~hpol_q;
      vsync_d       = (v_region == SYNC) ? vpol_q : ~vpol_q;
      de_d          = (h_region == ACTIVE) && (v_region == ACTIVE);
      pix_x_d       = h_cnt;
      pix_y_d       = v_cnt;
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      h_cfg_q       <= '0;
      v_cfg_q       <= '0;
      hpol_q        <= DEFAULT_HSYNC_POL;
      vpol_q        <= DEFAULT_HSYNC_POL;
      cfg_error_q   <= 1'b0;
      hsync_q       <= ~DEFAULT_HSYNC_POL;
      vsync_q       <= ~DEFAULT_HSYNC_POL;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cfg_q       <= h_cfg_d;
      v_cfg_q       <= v_cfg_d;
      hpol_q        <= hpol_d;
      vpol_q        <= vpol_d;
      cfg_error_q   <= cfg_error_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign running     = run;
  assign cfg_error   = cfg_error_q;

endmodule
